// File: rtl/execute_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ID/EX register, forwarding, ALU, HI/LO, iterative mul/div.
// Define MULT_FAST_EN for a single-cycle combinational MULT/MULTU; DIV/DIVU always stay iterative.
module execute_stage #(
    parameter int DATA_W   = 32,
    parameter int MD_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              jumpD,
    input  logic              ALUSrcD,
    input  logic              RegDstD,
    input  logic [1:0]        MemtoRegD,
    input  logic [2:0]        ALUControlD,
    input  logic [2:0]        MDOpD,
    input  logic [1:0]        ALUMultSelD,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [DATA_W-1:0] SignImmD,
    input  logic [DATA_W-1:0] PCPlus4D,
    input  logic [4:0]        RsD,
    input  logic [4:0]        RtD,
    input  logic [4:0]        RdD,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [DATA_W-1:0] ALUMultOutM,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              jumpE,
    output logic [1:0]        MemtoRegE,
    output logic [4:0]        WriteRegE,
    output logic [4:0]        RsE,
    output logic [4:0]        RtE,
    output logic [DATA_W-1:0] ALUMultOutE,
    output logic [DATA_W-1:0] WriteDataE,
    output logic [DATA_W-1:0] PCPlus4E,
    output logic              MDBusyE,
    output logic              MDStallE
);
    localparam int CNT_W = $clog2(MD_ITERS);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} md_state_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              jump;
        logic              alu_src;
        logic              reg_dst;
        logic [1:0]        mem_to_reg;
        logic [2:0]        alu_ctrl;
        logic [2:0]        md_op;
        logic [1:0]        alu_mult_sel;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] sign_imm;
        logic [DATA_W-1:0] pc_plus4;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
    } idex_t;

    idex_t               r_idex;
    idex_t               w_idex_d;
    md_state_t           r_state;
    logic [CNT_W-1:0]    r_count;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_op_b, r_hi, r_lo;
    logic                r_neg_q, r_neg_r, r_div_zero;

    logic [DATA_W-1:0]   w_src_a, w_write_data, w_src_b, w_alu;
    logic                w_md_busy, w_md_stall, w_md_start, w_md_last;
    logic                w_op_is_mul, w_op_signed, w_sign_a, w_sign_b, w_fast_mul;
    logic [DATA_W-1:0]   w_mag_a, w_mag_b, w_quot, w_rem;
    logic [DATA_W:0]     w_mul_sum, w_rem_shift, w_rem_diff;
    logic [2*DATA_W-1:0] w_mul_next, w_div_next, w_mul_res, w_fast_prod;

    assign w_idex_d = '{reg_write: RegWriteD, mem_write: MemWriteD, jump: jumpD, alu_src: ALUSrcD,
                        reg_dst: RegDstD, mem_to_reg: MemtoRegD, alu_ctrl: ALUControlD, md_op: MDOpD,
                        alu_mult_sel: ALUMultSelD, rd1: RD1D, rd2: RD2D, sign_imm: SignImmD,
                        pc_plus4: PCPlus4D, rs: RsD, rt: RtD, rd: RdD};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst || FlushE) begin
            r_idex <= '0;
        end else if (!(StallE || w_md_stall)) begin
            r_idex <= w_idex_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so an incomplete case cannot infer a latch.
        w_src_a      = r_idex.rd1;
        w_write_data = r_idex.rd2;
        case (ForwardAE)
            2'd1:    w_src_a = ResultW;
            2'd2:    w_src_a = ALUMultOutM;
            default: ;
        endcase
        case (ForwardBE)
            2'd1:    w_write_data = ResultW;
            2'd2:    w_write_data = ALUMultOutM;
            default: ;
        endcase
    end

    assign w_src_b = r_idex.alu_src ? r_idex.sign_imm : w_write_data;

    always_comb begin
        w_alu = '0;
        case (r_idex.alu_ctrl)
            3'b000:  w_alu = w_src_a & w_src_b;
            3'b001:  w_alu = w_src_a | w_src_b;
            3'b010:  w_alu = w_src_a + w_src_b;
            3'b110:  w_alu = w_src_a - w_src_b;
            3'b111:  w_alu = DATA_W'($signed(w_src_a) < $signed(w_src_b));
            default: ;
        endcase
    end

    always_comb begin
        ALUMultOutE = w_alu;
        case (r_idex.alu_mult_sel)
            2'd1:    ALUMultOutE = r_hi;
            2'd2:    ALUMultOutE = r_lo;
            default: ;
        endcase
    end

    assign w_md_busy  = (r_state != S_IDLE);
    assign w_md_stall = w_md_busy && ((r_idex.md_op != 3'd0) || (r_idex.alu_mult_sel != 2'd0));
    assign w_md_start = (r_state == S_IDLE) && (r_idex.md_op != 3'd0) && !StallE;
    assign w_md_last  = (r_count == CNT_W'(MD_ITERS - 1));

    // MULT=1, MULTU=2, DIV=3, DIVU=4; the iteration runs on magnitudes, signs are fixed up at the end.
    assign w_op_is_mul = (r_idex.md_op == 3'd1) || (r_idex.md_op == 3'd2);
    assign w_op_signed = (r_idex.md_op == 3'd1) || (r_idex.md_op == 3'd3);
    assign w_sign_a    = w_op_signed & w_src_a[DATA_W-1];
    assign w_sign_b    = w_op_signed & w_write_data[DATA_W-1];
    assign w_mag_a     = w_sign_a ? -w_src_a : w_src_a;
    assign w_mag_b     = w_sign_b ? -w_write_data : w_write_data;

    // Shift-add: the multiplier sits in the low half of r_acc and is consumed LSB first.
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_op_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};
    assign w_mul_res  = r_neg_q ? -w_mul_next : w_mul_next;

    // Restoring divide: remainder in the high half, quotient bits shift into the low half.
    assign w_rem_shift = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_op_b};
    assign w_div_next  = {w_rem_diff[DATA_W] ? w_rem_shift[DATA_W-1:0] : w_rem_diff[DATA_W-1:0],
                          r_acc[DATA_W-2:0], ~w_rem_diff[DATA_W]};
    assign w_quot      = r_div_zero ? '1 :
                         (r_neg_q ? -w_div_next[DATA_W-1:0] : w_div_next[DATA_W-1:0]);
    assign w_rem       = r_neg_r ? -w_div_next[2*DATA_W-1:DATA_W] : w_div_next[2*DATA_W-1:DATA_W];

`ifdef MULT_FAST_EN
    assign w_fast_prod = {{DATA_W{w_sign_a}}, w_src_a} * {{DATA_W{w_sign_b}}, w_write_data};
    assign w_fast_mul  = w_op_is_mul;
`else
    assign w_fast_prod = '0;
    assign w_fast_mul  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_acc      <= '0;
            r_op_b     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_start && w_fast_mul) begin
                        {r_hi, r_lo} <= w_fast_prod;
                    end else if (w_md_start) begin
                        r_state    <= w_op_is_mul ? S_MUL : S_DIV;
                        r_count    <= '0;
                        r_acc      <= {{DATA_W{1'b0}}, w_mag_a};
                        r_op_b     <= w_mag_b;
                        r_neg_q    <= w_sign_a ^ w_sign_b;
                        r_neg_r    <= w_sign_a;
                        r_div_zero <= !w_op_is_mul && (w_mag_b == '0);
                    end
                end
                S_MUL: begin
                    r_acc   <= w_mul_next;
                    r_count <= r_count + 1'b1;
                    if (w_md_last) begin
                        {r_hi, r_lo} <= w_mul_res;
                        r_state      <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_acc   <= w_div_next;
                    r_count <= r_count + 1'b1;
                    if (w_md_last) begin
                        r_hi    <= w_rem;
                        r_lo    <= w_quot;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign RegWriteE  = r_idex.reg_write & ~w_md_stall;
    assign MemWriteE  = r_idex.mem_write & ~w_md_stall;
    assign jumpE      = r_idex.jump;
    assign MemtoRegE  = r_idex.mem_to_reg;
    assign WriteRegE  = r_idex.reg_dst ? r_idex.rd : r_idex.rt;
    assign RsE        = r_idex.rs;
    assign RtE        = r_idex.rt;
    assign WriteDataE = w_write_data;
    assign PCPlus4E   = r_idex.pc_plus4;
    assign MDBusyE    = w_md_busy;
    assign MDStallE   = w_md_stall;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes expected writebacks, a monitor pops them on RegWriteE.
// Build with MULT_FAST_EN defined to exercise the single-cycle multiply variant.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst, StallE, FlushE;
    logic        RegWriteD, MemWriteD, jumpD, ALUSrcD, RegDstD;
    logic [1:0]  MemtoRegD, ALUMultSelD, ForwardAE, ForwardBE;
    logic [2:0]  ALUControlD, MDOpD;
    logic [31:0] RD1D, RD2D, SignImmD, PCPlus4D, ResultW, ALUMultOutM;
    logic [4:0]  RsD, RtD, RdD;
    logic        RegWriteE, MemWriteE, jumpE, MDBusyE, MDStallE;
    logic [1:0]  MemtoRegE;
    logic [4:0]  WriteRegE, RsE, RtE;
    logic [31:0] ALUMultOutE, WriteDataE, PCPlus4E;

`ifdef MULT_FAST_EN
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_BUSY = 32;
`endif

    typedef struct packed {
        logic        rw, mw, jmp, alusrc, regdst;
        logic [1:0]  m2r;
        logic [2:0]  aluc, mdop;
        logic [1:0]  sel;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  fa, fb;
        logic [31:0] res_w, alu_m;
    } instr_t;

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [4:0]  wreg;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    execute_stage dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .jumpD(jumpD), .ALUSrcD(ALUSrcD),
        .RegDstD(RegDstD), .MemtoRegD(MemtoRegD), .ALUControlD(ALUControlD), .MDOpD(MDOpD),
        .ALUMultSelD(ALUMultSelD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .PCPlus4D(PCPlus4D), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW), .ALUMultOutM(ALUMultOutM),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .jumpE(jumpE), .MemtoRegE(MemtoRegE),
        .WriteRegE(WriteRegE), .RsE(RsE), .RtE(RtE), .ALUMultOutE(ALUMultOutE),
        .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .MDBusyE(MDBusyE), .MDStallE(MDStallE)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every writeback the stage presents must match the oldest pending expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && RegWriteE === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_writeback: got wreg=%0d alu=%0h, required no writeback",
                         WriteRegE, ALUMultOutE);
            end else begin
                e = sb.pop_front();
                check({e.name, "_alu"}, 128'(ALUMultOutE), 128'(e.alu));
                check({e.name, "_wreg"}, 128'(WriteRegE), 128'(e.wreg));
            end
        end
    end

    task automatic drive_d(input instr_t i);
        RegWriteD = i.rw;   MemWriteD = i.mw;     jumpD = i.jmp;     ALUSrcD = i.alusrc;
        RegDstD = i.regdst; MemtoRegD = i.m2r;    ALUControlD = i.aluc;
        MDOpD = i.mdop;     ALUMultSelD = i.sel;  RD1D = i.rd1;      RD2D = i.rd2;
        SignImmD = i.imm;   PCPlus4D = i.pc4;     RsD = i.rs;        RtD = i.rt;   RdD = i.rd;
    endtask

    // Load into ID/EX, then present the forwarding inputs for its E cycle and leave a bubble on D.
    task automatic issue(input instr_t i);
        drive_d(i);
        @(posedge clk);
        #1;
        ForwardAE = i.fa;  ForwardBE = i.fb;  ResultW = i.res_w;  ALUMultOutM = i.alu_m;
        drive_d('0);
    endtask

    function automatic instr_t rtype(input logic [2:0] aluc, input logic [31:0] a, input logic [31:0] b);
        instr_t i = '0;
        i.rw = 1'b1;  i.regdst = 1'b1;  i.rd = 5'd3;  i.aluc = aluc;  i.rd1 = a;  i.rd2 = b;
        return i;
    endfunction

    task automatic alu_case(input string name, input instr_t i, input logic [31:0] exp_alu);
        exp_t e;
        e.name = name;  e.alu = exp_alu;  e.wreg = i.regdst ? i.rd : i.rt;
        sb.push_back(e);
        issue(i);
    endtask

    task automatic mf(input string name, input logic [1:0] sel, input logic [31:0] exp_val);
        instr_t i = '0;
        exp_t   e;
        i.rw = 1'b1;  i.regdst = 1'b1;  i.rd = 5'd8;  i.sel = sel;
        e.name = name;  e.alu = exp_val;  e.wreg = 5'd8;
        sb.push_back(e);
        issue(i);
    endtask

    // Issue a mul/div, follow it with a dependent MFHI/MFLO and measure the busy/stall window.
    task automatic md_run(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] sel, input logic [31:0] exp_val,
                          input int exp_busy);
        instr_t i = '0;
        int busy = 0, stall = 0, rwp = 0;
        i.mdop = op;  i.rd1 = a;  i.rd2 = b;  i.rs = 5'd1;  i.rt = 5'd2;
        issue(i);
        mf({name, "_rd"}, sel, exp_val);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!MDBusyE) break;
            busy++;
            if (MDStallE) stall++;
            if (RegWriteE) rwp++;
        end
        check({name, "_busy_cycles"}, 128'(busy), 128'(exp_busy));
        check({name, "_stall_cycles"}, 128'(stall), 128'(exp_busy));
        check({name, "_rw_in_stall"}, 128'(rwp), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t i;
        rst = 1'b1;  StallE = 1'b0;  FlushE = 1'b0;
        ForwardAE = 2'd0;  ForwardBE = 2'd0;  ResultW = '0;  ALUMultOutM = '0;
        drive_d('0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {RegWriteE, MemWriteE, jumpE, MemtoRegE, WriteRegE, RsE, RtE,
              ALUMultOutE, WriteDataE, PCPlus4E, MDBusyE, MDStallE}, 128'(0));
        rst = 1'b0;

        i = rtype(3'b010, 32'd99, 32'd5);  i.fa = 2'd2;  i.alu_m = 32'd10;
        alu_case("add_fwd_m", i, 32'd15);
        i = rtype(3'b010, 32'd99, 32'd5);  i.fa = 2'd1;  i.res_w = 32'd7;
        alu_case("add_fwd_w", i, 32'd12);
        i = rtype(3'b010, 32'd20, 32'd5);  i.fa = 2'd3;  i.res_w = 32'd7;  i.alu_m = 32'd9;
        alu_case("add_fwd_code3", i, 32'd25);
        i = rtype(3'b110, 32'd30, 32'd99); i.fb = 2'd2;  i.alu_m = 32'd8;
        alu_case("sub_fwd_b", i, 32'd22);
        alu_case("and", rtype(3'b000, 32'h0000F0F0, 32'h0000FF00), 32'h0000F000);
        alu_case("or",  rtype(3'b001, 32'h0000F0F0, 32'h00000F0F), 32'h0000FFFF);
        alu_case("slt_neg", rtype(3'b111, 32'hFFFFFFFF, 32'd1), 32'd1);
        alu_case("slt_pos", rtype(3'b111, 32'd1, 32'hFFFFFFFF), 32'd0);
        alu_case("alu_bad_code", rtype(3'b011, 32'd5, 32'd3), 32'd0);
        i = rtype(3'b010, 32'd100, 32'd0); i.alusrc = 1'b1;  i.imm = 32'hFFFFFFFC;
        i.regdst = 1'b0;  i.rt = 5'd9;
        alu_case("addi_rt", i, 32'd96);
        i = rtype(3'b010, 32'd1, 32'd2);   i.sel = 2'd3;
        alu_case("sel3_alu", i, 32'd3);

        md_run("mult", 3'd1, 32'hFFFFFFFD, 32'd5, 2'd2, 32'hFFFFFFF1, MUL_BUSY);
        mf("mult_hi", 2'd1, 32'hFFFFFFFF);
        md_run("divu", 3'd4, 32'd100, 32'd7, 2'd2, 32'd14, 32);
        mf("divu_hi", 2'd1, 32'd2);
        md_run("div", 3'd3, 32'hFFFFFFF9, 32'd2, 2'd2, 32'hFFFFFFFD, 32);
        mf("div_hi", 2'd1, 32'hFFFFFFFF);
        md_run("divu_by0", 3'd4, 32'd9, 32'd0, 2'd2, 32'hFFFFFFFF, 32);
        mf("divu_by0_hi", 2'd1, 32'd9);
        md_run("div_by0", 3'd3, 32'hFFFFFFF7, 32'd0, 2'd1, 32'hFFFFFFF7, 32);
        mf("div_by0_lo", 2'd2, 32'hFFFFFFFF);
        md_run("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 2'd1, 32'd1, MUL_BUSY);
        mf("multu_lo", 2'd2, 32'hFFFFFFFE);

        // Flush turns a writing instruction into a bubble.
        i = '0;  i.rw = 1'b1;  i.mw = 1'b1;  i.regdst = 1'b1;  i.rd = 5'd7;
        drive_d(i);
        FlushE = 1'b1;
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        drive_d('0);
        check("flush_rw", 128'(RegWriteE), 128'(0));
        check("flush_mw", 128'(MemWriteE), 128'(0));
        check("flush_wreg", 128'(WriteRegE), 128'(0));

        // Stall holds a store in E while D changes underneath it.
        i = '0;  i.mw = 1'b1;  i.alusrc = 1'b1;  i.aluc = 3'b010;  i.rd1 = 32'd100;
        i.imm = 32'd8;  i.rd2 = 32'h55;  i.pc4 = 32'h40;  i.rs = 5'd2;  i.rt = 5'd4;
        issue(i);
        check("store_alu", 128'(ALUMultOutE), 128'(32'd108));
        check("store_wdata", 128'(WriteDataE), 128'(32'h55));
        StallE = 1'b1;
        i = rtype(3'b001, 32'd1, 32'd2);  i.pc4 = 32'h80;  i.rs = 5'd11;  i.rt = 5'd12;
        drive_d(i);
        repeat (2) @(posedge clk);
        #1;
        check("stall_alu", 128'(ALUMultOutE), 128'(32'd108));
        check("stall_wdata", 128'(WriteDataE), 128'(32'h55));
        check("stall_pc4", 128'(PCPlus4E), 128'(32'h40));
        check("stall_ctrl", 128'({RegWriteE, MemWriteE, WriteRegE, RsE, RtE}),
              128'({1'b0, 1'b1, 5'd4, 5'd2, 5'd4}));
        StallE = 1'b0;
        drive_d('0);

        // Reset in the middle of a divide aborts it and clears HI/LO.
        i = '0;  i.mdop = 3'd3;  i.rd1 = 32'd1000;  i.rd2 = 32'd3;
        issue(i);
        repeat (9) @(posedge clk);
        i = '0;  i.mw = 1'b1;  i.rd1 = 32'd5;  i.pc4 = 32'h44;  i.rt = 5'd6;
        issue(i);
        check("pre_rst_busy", 128'(MDBusyE), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", 128'(MDBusyE), 128'(0));
        check("rst_outputs", {RegWriteE, MemWriteE, jumpE, MemtoRegE, WriteRegE, RsE, RtE,
              ALUMultOutE, WriteDataE, PCPlus4E, MDBusyE, MDStallE}, 128'(0));
        rst = 1'b0;
        mf("rst_hi", 2'd1, 32'd0);
        mf("rst_lo", 2'd2, 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (E) stage of the 5-stage pipelined MIPS core; sits between decode and the memory stage and drives its E-side inputs.
- Contains the ID/EX pipeline register, forwarding muxes, the ALU, the HI/LO registers and an iterative multiply/divide unit.
- Produces the ALU or HI/LO result (ALUMultOutE), store data and destination register for the memory stage.
- Raises MDStallE so the hazard unit can stall F/D while the multiply/divide unit is busy.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- MD_ITERS, 32, iterations per multiply/divide; equal to DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- StallE  in  1  hold the ID/EX register
- FlushE  in  1  load a bubble into the ID/EX register
- RegWriteD, MemWriteD, jumpD, ALUSrcD, RegDstD  in  1 each  decode controls
- MemtoRegD  in  2  writeback select, passed through
- ALUControlD  in  3  ALU op
- MDOpD  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
- ALUMultSelD  in  2  0 ALU, 1 HI, 2 LO
- RD1D, RD2D, SignImmD, PCPlus4D  in  32  decode operands
- RsD, RtD, RdD  in  5  register specifiers
- ForwardAE, ForwardBE  in  2  0 register file, 1 ResultW, 2 ALUMultOutM
- ResultW, ALUMultOutM  in  32  forwarded values
- RegWriteE, MemWriteE, jumpE  out  1  to the memory stage
- MemtoRegE  out  2  to the memory stage
- WriteRegE, RsE, RtE  out  5  destination register; source specifiers for the hazard unit
- ALUMultOutE, WriteDataE, PCPlus4E  out  32  to the memory stage
- MDBusyE, MDStallE  out  1  unit busy; stall request

Behaviour:
- ID/EX register, updated at posedge clk, priority order:
  - rst: all fields 0.
  - FlushE: all fields 0 (bubble).
  - StallE or MDStallE: hold.
  - Otherwise: load the D inputs.
- Reset value of every output is 0; HI=LO=0; multiply/divide state IDLE.
- Operand selection:
  - SrcAE = forwarding mux on RD1E.
  - WriteDataE = forwarding mux on RD2E.
  - SrcBE = ALUSrcE ? SignImmE : WriteDataE.
  - Forward code 3 selects the register-file value, same as code 0.
- WriteRegE = RegDstE ? RdE : RtE.
- ALU (combinational):
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed).
  - Any other code gives 0.
  - Overflow is ignored.
- ALUMultOutE = ALU result, HI or LO per ALUMultSelE. Select code 3 gives the ALU result.
- Multiply/divide FSM states: IDLE, MUL, DIV.
  - Start: on the edge where state==IDLE, MDOpE!=0 and StallE==0, latch operand magnitudes and sign flags, set count=0, go to MUL or DIV.
  - Each later edge performs one shift-add (MUL) or one restoring-divide step (DIV).
  - On the edge with count==MD_ITERS-1: apply sign correction, write {HI,LO}, return to IDLE.
  - Latency: 32 busy cycles after the start edge; a dependent MFHI/MFLO reads the new value in the first IDLE cycle.
  - MULT/MULTU result: HI = upper 32 bits, LO = lower 32 bits of the 64-bit product.
  - DIV/DIVU result: LO = quotient, HI = remainder. Signed remainder takes the sign of the dividend.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend (unsigned and signed alike).
- MDBusyE = (state != IDLE).
- MDStallE = MDBusyE and (MDOpE!=0 or ALUMultSelE!=0), combinational.
  - While MDStallE is high, RegWriteE and MemWriteE are forced to 0, so the memory stage receives a bubble.
  - The hazard unit stalls F/D on MDStallE.
- An issued multiply/divide is not cancelled by FlushE or StallE. Only rst aborts it: state IDLE, HI=LO=0.
- A multiply/divide op has RegWriteD=0 (decode guarantees this); this block does not check it.

Optional Feature:
- Macro: MULT_FAST_EN.
- Defined: MULT and MULTU complete in one cycle (combinational 32x32 multiply, HI/LO written on the start edge, state stays IDLE, MDBusyE never asserts for a multiply). DIV/DIVU stay iterative.
- Undefined: both multiply and divide use the 32-iteration FSM as above.

Test Plan:
- ADD with ForwardAE=2, ALUMultOutM=10, RD2D=5, ALUControl=010 -> ALUMultOutE=15; ForwardAE=1, ResultW=7 -> ALUMultOutE=12.
- MULT -3*5 followed by MFLO -> MDStallE high for 32 cycles; then LO=0xFFFFFFF1, HI=0xFFFFFFFF, ALUMultOutE=0xFFFFFFF1, no RegWriteE pulse during the stall.
- DIVU 100/7 -> LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
- rst asserted at iteration 10 of a DIV -> next cycle MDBusyE=0, HI=LO=0, all outputs 0.
- FlushE with RegWriteD=1, MemWriteD=1 -> next cycle RegWriteE=0, MemWriteE=0, WriteRegE=0; StallE holds all E outputs unchanged.
- With MULT_FAST_EN: MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE on the cycle after issue, MDBusyE never asserted.
